sipo_stream: RTL

//  Parametrised serial-to-parallel deserialiser. Assembles WIDTH-bit words from

---
 rtl/sipo_stream.sv | 116 +++++++++++
 1 files changed

// File: rtl/sipo_stream.sv
// Serial-to-parallel deserialiser with a valid/ready holding register.
// Optional parity beat per word when SIPO_PARITY_EN is defined.
module sipo_stream #(
    parameter int WIDTH     = 8,
    parameter int LANES     = 1,
    parameter bit SHIFT_DIR = 1'b0,
    parameter bit ODD_PAR   = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [LANES-1:0] in_data,
    input  logic             clear,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    output logic             par_err
);

    localparam int BEATS = WIDTH / LANES;
`ifdef SIPO_PARITY_EN
    localparam int TOTAL = BEATS + 1;
`else
    localparam int TOTAL = BEATS;
`endif
    localparam int CW = $clog2(TOTAL + 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_overflow;
    logic             r_par_err;

    logic             w_beat;
    logic             w_last;
    logic             w_load;
    logic             w_drop;
    logic             w_par_bad;
    logic [WIDTH-1:0] w_asm_next;

    assign w_beat = in_valid && !clear;
    assign w_last = w_beat && (r_cnt == CW'(TOTAL - 1));
    assign w_load = w_last && (!r_out_valid || out_ready);
    assign w_drop = w_last && r_out_valid && !out_ready;

    // Merge the current data beat so a completing word can load the hold directly.
    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < BEATS; k++) begin
            if (w_beat && (r_cnt == CW'(k))) begin
                if (SHIFT_DIR)
                    w_asm_next[WIDTH-(k+1)*LANES +: LANES] = in_data;
                else
                    w_asm_next[k*LANES +: LANES] = in_data;
            end
        end
    end

    assign w_par_bad = ((^w_asm_next) ^ in_data[0]) != ODD_PAR;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_asm  <= '0;
            r_busy <= 1'b0;
        end else if (clear) begin
            r_cnt  <= '0;
            r_asm  <= '0;
            r_busy <= 1'b0;
        end else if (w_beat) begin
            if (w_last) begin
                r_cnt  <= '0;
                r_asm  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_asm  <= w_asm_next;
                r_busy <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_par_err   <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_load) begin
                r_out_data  <= w_asm_next;
                r_out_valid <= 1'b1;
                r_par_err   <= w_par_bad;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign overflow  = r_overflow;
`ifdef SIPO_PARITY_EN
    assign par_err   = r_par_err;
`else
    // Without a parity beat the flag is meaningless; keep it low.
    assign par_err   = r_par_err & 1'b0;
`endif

endmodule
